tile_read_streamer: RTL and testbench

- Reads a contiguous or strided block of NumPorts-wide vectors out of a multi_port_memory instance and presents them as a valid/ready stream to the downstream compute stage (PE array input).
- Drives every memory port with one address per cycle and absorbs the memory's fixed 1-cycle read latency.
- Contains a 2-entry buffer so downstream backpressure never drops or duplicates data.
- Sits directly downstream of multi_port_memory; its memory-side ports connect 1:1 to that block.

---
 rtl/tile_streamer_pkg.sv | 17 +
 rtl/stream_fifo.sv | 63 ++++++
 rtl/tile_read_streamer.sv | 183 ++++++++++++++++++
 tb/tb_tile_read_streamer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tile_streamer_pkg.sv
// Shared types and constants for the tile read streamer.
package tile_streamer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Output buffer depth: covers one read in flight plus one beat held under stall.
  localparam int BufDepth = 2;

  // Width of the backpressure cycle counter.
  localparam int StallCntW = 32;

endpackage

// File: rtl/stream_fifo.sv
// Small in-order FIFO with valid/ready on both sides and an occupancy count.
// A push into a full FIFO is accepted when a pop happens in the same cycle.
module stream_fifo #(
  parameter int Depth = 2,
  parameter int Width = 32,
  localparam int PtrW = (Depth <= 1) ? 1 : $clog2(Depth),
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [Width-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [Width-1:0] out_data_o,
  output logic [CntW-1:0]  count_o
);

  logic [Width-1:0] r_mem [Depth];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [CntW-1:0]  r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == PtrW'(Depth - 1)) ? '0 : ptr + PtrW'(1);
  endfunction

  assign in_ready_o  = (r_count != CntW'(Depth)) || out_ready_i;
  assign out_valid_o = (r_count != '0);
  assign w_push      = in_valid_i && in_ready_o;
  assign w_pop       = out_valid_o && out_ready_i;
  assign out_data_o  = r_mem[r_rd_ptr];
  assign count_o     = r_count;

  // Storage, pointers and occupancy; storage is cleared so the output reads 0 after reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data_i;
        r_wr_ptr        <= ptr_inc(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/tile_read_streamer.sv
// Streams a contiguous or strided block of NumPorts-wide vectors out of a
// multi-port memory with a fixed 1-cycle read latency, as a valid/ready stream.
// Reads are only issued when the 2-entry buffer is guaranteed room, so
// backpressure never drops or duplicates a beat.
// Optional: define TILE_STREAMER_STALL_CNT_EN to build the saturating
// backpressure counter on stall_cnt_o (otherwise it is tied to 0).
module tile_read_streamer
  import tile_streamer_pkg::*;
#(
  parameter int DataWidth = 8,
  parameter int NumPorts  = 4,
  parameter int DataDepth = 4096,
  parameter int AddrWidth = (DataDepth <= 1) ? 1 : $clog2(DataDepth),
  parameter int LenWidth  = 16
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  input  logic                                    start_i,
  input  logic        [AddrWidth-1:0]             base_addr_i,
  input  logic        [LenWidth-1:0]              stride_i,
  input  logic        [LenWidth-1:0]              num_vec_i,
  output logic                                    busy_o,
  output logic                                    done_o,
  output logic        [NumPorts-1:0][AddrWidth-1:0] mem_addr_o,
  output logic        [NumPorts-1:0]              mem_we_o,
  input  logic signed [NumPorts-1:0][DataWidth-1:0] mem_rd_data_i,
  output logic signed [NumPorts-1:0][DataWidth-1:0] out_data_o,
  output logic                                    out_valid_o,
  input  logic                                    out_ready_i,
  output logic        [StallCntW-1:0]             stall_cnt_o
);

  localparam int AccW = AddrWidth + LenWidth;
  localparam int CntW = $clog2(BufDepth + 1);
  localparam int OccW = CntW + 1;

  state_t                             r_state;
  state_t                             w_next_state;
  logic   [AccW-1:0]                  r_vec_addr;
  logic   [LenWidth-1:0]              r_stride;
  logic   [LenWidth-1:0]              r_remaining;
  logic                               r_inflight;
  logic                               r_done;
  logic   [NumPorts-1:0][AddrWidth-1:0] r_addr;
  logic   [NumPorts-1:0][AddrWidth-1:0] w_addr;
  logic                               w_accept;
  logic                               w_issue;
  logic                               w_pop;
  logic                               w_push;
  logic                               w_fifo_in_ready;
  logic   [CntW-1:0]                  w_fifo_count;
  logic   [OccW-1:0]                  w_occupancy;
  logic   [OccW-1:0]                  w_limit;
  logic   [NumPorts*DataWidth-1:0]    w_fifo_out;

  assign w_pop    = out_valid_o && out_ready_i;
  // The issue rule already guarantees room; the gate only keeps a push from
  // ever landing on a full buffer.
  assign w_push   = r_inflight && w_fifo_in_ready;
  assign busy_o   = (r_state == RUN) || (r_state == DRAIN);
  assign done_o   = r_done;
  assign mem_we_o = '0;
  assign out_data_o = w_fifo_out;

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next state, start acceptance and read issue (credit: buffered + in flight - popping < depth).
  always_comb begin
    w_next_state = r_state;
    w_accept     = 1'b0;
    w_issue      = 1'b0;
    w_occupancy  = OccW'(w_fifo_count) + OccW'(r_inflight);
    w_limit      = OccW'(BufDepth) + OccW'(w_pop);
    case (r_state)
      IDLE: begin
        if (start_i) begin
          w_accept     = 1'b1;
          w_next_state = (num_vec_i == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (w_occupancy < w_limit) begin
          w_issue = 1'b1;
          if (r_remaining == LenWidth'(1)) begin
            w_next_state = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (!r_inflight &&
            ((w_fifo_count == '0) || ((w_fifo_count == CntW'(1)) && w_pop))) begin
          w_next_state = DONE;
        end
      end
      DONE: begin
        w_next_state = IDLE;
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Per-port addresses of the current vector; wrap-around is silent truncation.
  always_comb begin
    for (int p = 0; p < NumPorts; p++) begin
      w_addr[p] = r_vec_addr[AddrWidth-1:0] + AddrWidth'(p);
    end
  end

  // The bus shows the vector being read this cycle and otherwise holds the last one.
  assign mem_addr_o = w_issue ? w_addr : r_addr;

  // Job parameters, vector address accumulator, read-in-flight flag and done pulse.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_vec_addr  <= '0;
      r_stride    <= '0;
      r_remaining <= '0;
      r_inflight  <= 1'b0;
      r_done      <= 1'b0;
      r_addr      <= '0;
    end else begin
      r_inflight <= w_issue;
      r_done     <= (r_state == DONE);
      if (w_accept) begin
        r_vec_addr  <= AccW'(base_addr_i);
        r_stride    <= stride_i;
        r_remaining <= num_vec_i;
      end else if (w_issue) begin
        r_vec_addr  <= r_vec_addr + AccW'(r_stride);
        r_remaining <= r_remaining - LenWidth'(1);
        r_addr      <= w_addr;
      end
    end
  end

  stream_fifo #(
    .Depth (BufDepth),
    .Width (NumPorts * DataWidth)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .in_valid_i  (w_push),
    .in_ready_o  (w_fifo_in_ready),
    .in_data_i   (mem_rd_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (w_fifo_out),
    .count_o     (w_fifo_count)
  );

`ifdef TILE_STREAMER_STALL_CNT_EN
  logic [StallCntW-1:0] r_stall_cnt;

  function automatic logic [StallCntW-1:0] sat_inc(input logic [StallCntW-1:0] v);
    return (v == '1) ? v : v + StallCntW'(1);
  endfunction

  // Backpressure cycles of the current job; cleared on start, held after done.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
    end else if (w_accept) begin
      r_stall_cnt <= '0;
    end else if (out_valid_o && !out_ready_i) begin
      r_stall_cnt <= sat_inc(r_stall_cnt);
    end
  end

  assign stall_cnt_o = r_stall_cnt;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_tile_read_streamer.sv
module tb_tile_read_streamer;

  localparam int DW = 8;
  localparam int NP = 4;
  localparam int DD = 4096;
  localparam int AW = 12;
  localparam int LW = 16;

  logic                          clk_i = 1'b0;
  logic                          rst_i = 1'b1;
  logic                          start_i = 1'b0;
  logic        [AW-1:0]          base_addr_i = '0;
  logic        [LW-1:0]          stride_i = '0;
  logic        [LW-1:0]          num_vec_i = '0;
  logic                          busy_o;
  logic                          done_o;
  logic        [NP-1:0][AW-1:0]  mem_addr_o;
  logic        [NP-1:0]          mem_we_o;
  logic signed [NP-1:0][DW-1:0]  mem_rd_data_i;
  logic signed [NP-1:0][DW-1:0]  out_data_o;
  logic                          out_valid_o;
  logic                          out_ready_i = 1'b1;
  logic        [31:0]            stall_cnt_o;
  logic        [NP*DW-1:0]       out_data_u;

  assign out_data_u = out_data_o;

  always #5 clk_i = ~clk_i;

  tile_read_streamer #(
    .DataWidth (DW),
    .NumPorts  (NP),
    .DataDepth (DD),
    .AddrWidth (AW),
    .LenWidth  (LW)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .base_addr_i   (base_addr_i),
    .stride_i      (stride_i),
    .num_vec_i     (num_vec_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .mem_addr_o    (mem_addr_o),
    .mem_we_o      (mem_we_o),
    .mem_rd_data_i (mem_rd_data_i),
    .out_data_o    (out_data_o),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .stall_cnt_o   (stall_cnt_o)
  );

  // Memory model: registered read, data valid one cycle after the address.
  logic [DW-1:0] mem [DD];
  always @(posedge clk_i) begin
    for (int p = 0; p < NP; p++) begin
      mem_rd_data_i[p] <= mem[mem_addr_o[p]];
    end
  end

  int cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  int beats, done_cnt, stall_obs;
  int first_valid_cyc, first_beat_cyc, last_beat_cyc, done_cyc, start_cyc;
  int ready_mode = 0;
  logic [NP*DW-1:0] first_data, last_data;
  logic [NP*DW-1:0] exp_q[$];

  typedef struct {
    int               base;
    int               stride;
    int               num;
    int               rmode;
    int               exp_beats;
    logic [NP*DW-1:0] exp_first;
    logic [NP*DW-1:0] exp_last;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [NP*DW-1:0] exp_vec(input int b, input int s, input int k);
    logic [NP*DW-1:0] v;
    logic [31:0] a;
    v = '0;
    for (int p = 0; p < NP; p++) begin
      a = (b + k * s + p) & (DD - 1);
      v[p*DW +: DW] = a[DW-1:0];
    end
    return v;
  endfunction

  // Ready pattern: 0 = always ready, 1 = random 50%.
  initial begin
    forever begin
      @(posedge clk_i);
      #1;
      if (ready_mode == 0) out_ready_i = 1'b1;
      else out_ready_i = ($urandom_range(0, 1) == 1);
    end
  end

  // Output monitor and scoreboard.
  initial begin
    logic             prev_stall;
    logic [NP*DW-1:0] prev_data;
    logic [NP*DW-1:0] e;
    prev_stall = 1'b0;
    prev_data  = '0;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("hold_valid", out_valid_o, 1);
          chk("hold_data", out_data_u, prev_data);
        end
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (out_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
        if (out_valid_o && out_ready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none", out_data_u);
          end else begin
            e = exp_q.pop_front();
            chk("beat_data", out_data_u, e);
          end
          if (first_beat_cyc < 0) begin
            first_beat_cyc = cyc;
            first_data     = out_data_u;
          end
          last_beat_cyc = cyc;
          last_data     = out_data_u;
          beats++;
        end
        if (out_valid_o && !out_ready_i) stall_obs++;
        prev_stall = out_valid_o && !out_ready_i;
        prev_data  = out_data_u;
      end
    end
  end

  task automatic start_job(input int b, input int s, input int n);
    @(posedge clk_i);
    #1;
    base_addr_i = AW'(b);
    stride_i    = LW'(s);
    num_vec_i   = LW'(n);
    start_i     = 1'b1;
    for (int k = 0; k < n; k++) exp_q.push_back(exp_vec(b, s, k));
    first_valid_cyc = -1;
    first_beat_cyc  = -1;
    last_beat_cyc   = -1;
    beats           = 0;
    done_cnt        = 0;
    stall_obs       = 0;
    @(posedge clk_i);
    #1;
    start_cyc = cyc;
    start_i   = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string name);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      @(posedge clk_i);
      #1;
      n++;
    end
    chk({name, "_done_seen"}, (done_cnt != 0), 1);
    repeat (4) @(posedge clk_i);
    #1;
  endtask

  task automatic run_row(input vec_t v, input string name);
    ready_mode = v.rmode;
    start_job(v.base, v.stride, v.num);
    chk({name, "_busy"}, busy_o, 1);
    chk({name, "_we"}, mem_we_o, 0);
    wait_done(v.num * 8 + 100, name);
    chk({name, "_beats"}, beats, v.exp_beats);
    chk({name, "_first"}, first_data, v.exp_first);
    chk({name, "_last"}, last_data, v.exp_last);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_one_done"}, done_cnt, 1);
    chk({name, "_latency"}, first_valid_cyc - start_cyc, 2);
    chk({name, "_idle_busy"}, busy_o, 0);
    if (v.rmode == 0) chk({name, "_throughput"}, last_beat_cyc - first_beat_cyc, v.num - 1);
`ifdef TILE_STREAMER_STALL_CNT_EN
    chk({name, "_stall_cnt"}, stall_cnt_o, stall_obs);
`else
    chk({name, "_stall_cnt"}, stall_cnt_o, 0);
`endif
  endtask

  initial begin
    vec_t tbl[5];
    vec_t after_rst;
    int   n;

    tbl[0] = '{0,    4,     1024, 0, 1024, 32'h03020100, 32'hFFFEFDFC};
    tbl[1] = '{4092, 4,     3,    0, 3,    32'hFFFEFDFC, 32'h07060504};
    tbl[2] = '{100,  7,     64,   1, 64,   32'h67666564, 32'h201F1E1D};
    tbl[3] = '{10,   0,     5,    1, 5,    32'h0D0C0B0A, 32'h0D0C0B0A};
    tbl[4] = '{4000, 65535, 8,    0, 8,    32'hA3A2A1A0, 32'h9C9B9A99};
    after_rst = '{0, 4, 16, 0, 16, 32'h03020100, 32'h3F3E3D3C};

    for (int a = 0; a < DD; a++) mem[a] = a[DW-1:0];

    // Reset state.
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_data", out_data_u, 0);
    chk("rst_addr", mem_addr_o, 0);
    chk("rst_we", mem_we_o, 0);
    chk("rst_stall", stall_cnt_o, 0);
    rst_i = 1'b0;

    for (int i = 0; i < 5; i++) begin
      run_row(tbl[i], $sformatf("row%0d", i));
    end

    // Zero-length job: done only, no beats.
    ready_mode = 0;
    start_job(5, 1, 0);
    wait_done(20, "zero");
    chk("zero_done_time", done_cyc - start_cyc, 1);
    chk("zero_no_valid", first_valid_cyc, -1);
    chk("zero_one_done", done_cnt, 1);
    chk("zero_beats", beats, 0);

    // Start pulse during RUN is ignored.
    ready_mode = 1;
    start_job(200, 3, 20);
    repeat (5) @(posedge clk_i);
    #1;
    chk("ign_busy", busy_o, 1);
    base_addr_i = AW'(999);
    num_vec_i   = LW'(7);
    start_i     = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    wait_done(400, "ign");
    chk("ign_beats", beats, 20);
    chk("ign_queue_empty", exp_q.size(), 0);
    chk("ign_one_done", done_cnt, 1);

    // Asynchronous reset mid-stream after 10 beats, then a clean restart.
    ready_mode = 0;
    start_job(0, 4, 40);
    n = 0;
    while (beats < 10 && n < 200) begin
      @(negedge clk_i);
      n++;
    end
    chk("mid_ten_beats", (beats >= 10), 1);
    #2;
    rst_i = 1'b1;
    #1;
    chk("mid_busy", busy_o, 0);
    chk("mid_done", done_o, 0);
    chk("mid_valid", out_valid_o, 0);
    chk("mid_data", out_data_u, 0);
    chk("mid_addr", mem_addr_o, 0);
    chk("mid_stall", stall_cnt_o, 0);
    exp_q.delete();
    @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    run_row(after_rst, "after_rst");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
